// File: rtl/clocking_types.sv
// Shared clocking types for the phase measurement path: handshake structs,
// delay width, averaging/retry constants and the scheduler state encoding.
// PHASE_MEASURE_TRACK_EN adds the HOLDOFF state and the tracking interval.
package clocking_types;

  localparam int DELAY_WIDTH  = 9;
  localparam int LOG2_SAMPLES = 2;
  localparam int NUM_SAMPLES  = 1 << LOG2_SAMPLES;
  localparam int RETRY_LIMIT  = 7;
`ifdef PHASE_MEASURE_TRACK_EN
  localparam int TRACK_INTERVAL = 1024;
`endif

  typedef logic [DELAY_WIDTH-1:0] t_delay;

  typedef struct packed {
    logic valid;
  } t_measure_request;

  typedef struct packed {
    logic   valid;
    logic   abort;
    logic   initial_value;
    t_delay initial_delay;
    t_delay delay;
  } t_measure_response;

  typedef struct packed {
    logic   load;
    t_delay value;
  } t_delay_config;

  typedef struct packed {
    logic load_ack;
  } t_delay_response;

  typedef enum logic [3:0] {
    S_IDLE,
    S_REQUEST,
    S_WAIT_RESP,
    S_ACCUM,
    S_COMPUTE,
    S_LOAD,
    S_LOCKED,
    S_FAIL
`ifdef PHASE_MEASURE_TRACK_EN
    , S_HOLDOFF
`endif
  } t_phase_sched_state;

endpackage

// File: rtl/phase_centre_average.sv
// Eye-centre estimator: centre = initial_delay + delay/2 (saturated to the
// tap range), summed over NUM_SAMPLES measurements and divided by shifting.
module phase_centre_average
  import clocking_types::*;
(
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   clear,
  input  logic                   add,
  input  logic [DELAY_WIDTH-1:0] initial_delay,
  input  logic [DELAY_WIDTH-1:0] delay,
  output logic [DELAY_WIDTH-1:0] average
);

  logic [DELAY_WIDTH:0]                centre_wide;
  logic [DELAY_WIDTH-1:0]              centre;
  logic [DELAY_WIDTH+LOG2_SAMPLES-1:0] acc;

  // Centre of the eye, one bit wider so an overflow past the last tap saturates.
  // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
  always_comb begin
    centre_wide = {1'b0, initial_delay} + ({1'b0, delay} >> 1);
    centre      = centre_wide[DELAY_WIDTH] ? '1 : centre_wide[DELAY_WIDTH-1:0];
  end

  // Sum of centres; wide enough that NUM_SAMPLES saturated centres never wrap.
  // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc <= '0;
    end else if (clear) begin
      acc <= '0;
    end else if (add) begin
      acc <= acc + {{LOG2_SAMPLES{1'b0}}, centre};
    end
  end

  // Truncating average.
  assign average = acc[DELAY_WIDTH+LOG2_SAMPLES-1:LOG2_SAMPLES];

endmodule

// File: rtl/phase_measure_scheduler.sv
// Sequencer for clocking_phase_measure: requests measurements, retries on
// abort, averages the eye-centre estimates and loads the result into the
// data-path delay line. Define PHASE_MEASURE_TRACK_EN for periodic re-measurement
// while locked; otherwise LOCKED is held until enable drops.
module phase_measure_scheduler
  import clocking_types::*;
(
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   enable,
  output logic                   measure_request__valid,
  input  logic                   measure_response__valid,
  input  logic                   measure_response__abort,
  input  logic                   measure_response__initial_value,
  input  logic [DELAY_WIDTH-1:0] measure_response__initial_delay,
  input  logic [DELAY_WIDTH-1:0] measure_response__delay,
  output logic                   measure_response__ack,
  output logic                   data_delay__load,
  output logic [DELAY_WIDTH-1:0] data_delay__value,
  input  logic                   data_delay__load_ack,
  output logic                   status__locked,
  output logic                   status__failed,
  output logic [DELAY_WIDTH-1:0] status__phase,
  output logic [2:0]             status__retries
);

  localparam logic [2:0] RETRY_LAST = 3'(RETRY_LIMIT - 1);

  t_phase_sched_state       state;
  logic [LOG2_SAMPLES-1:0]  sample_cnt;
  logic [DELAY_WIDTH-1:0]   resp_init_q;
  logic [DELAY_WIDTH-1:0]   resp_delay_q;
  t_delay_config            dd_q;
  logic                     acc_clear;
  logic                     acc_add;
  logic [DELAY_WIDTH-1:0]   average;
  logic                     unused_initial_value;

`ifdef PHASE_MEASURE_TRACK_EN
  localparam int             IW            = $clog2(TRACK_INTERVAL);
  localparam logic [IW-1:0]  INTERVAL_LAST = IW'(TRACK_INTERVAL - 1);
  logic [IW-1:0]             interval_cnt;
`endif

  // The sampled initial level is informational only.
  assign unused_initial_value = measure_response__initial_value;

  assign data_delay__load  = dd_q.load;
  assign data_delay__value = dd_q.value;

  // Accumulator is cleared at the start of each averaging run and fed from the latched response.
  always_comb begin
    acc_clear = (state == S_IDLE) && enable;
    acc_add   = (state == S_ACCUM);
`ifdef PHASE_MEASURE_TRACK_EN
    if (state == S_HOLDOFF) acc_clear = 1'b1;
`endif
  end

  phase_centre_average u_average (
    .clk           (clk),
    .reset_n       (reset_n),
    .clear         (acc_clear),
    .add           (acc_add),
    .initial_delay (resp_init_q),
    .delay         (resp_delay_q),
    .average       (average)
  );

  // Scheduler FSM; every output is registered with the state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state                  <= S_IDLE;
      measure_request__valid <= 1'b0;
      measure_response__ack  <= 1'b0;
      dd_q                   <= '0;
      status__locked         <= 1'b0;
      status__failed         <= 1'b0;
      status__phase          <= '0;
      status__retries        <= '0;
      sample_cnt             <= '0;
      resp_init_q            <= '0;
      resp_delay_q           <= '0;
`ifdef PHASE_MEASURE_TRACK_EN
      interval_cnt           <= '0;
`endif
    end else begin
      // Ack is a single-cycle pulse.
      measure_response__ack <= 1'b0;
`ifdef PHASE_MEASURE_TRACK_EN
      if (state != S_LOCKED) interval_cnt <= '0;
`endif
      case (state)
        S_IDLE: begin
          if (enable) begin
            sample_cnt      <= '0;
            status__retries <= '0;
            status__locked  <= 1'b0;
            status__failed  <= 1'b0;
            state           <= S_REQUEST;
          end
        end
        S_REQUEST: begin
          if (!enable) begin
            state <= S_IDLE;
          end else begin
            measure_request__valid <= 1'b1;
            state                  <= S_WAIT_RESP;
          end
        end
        // The outstanding request is always answered and acked, even when abandoning.
        S_WAIT_RESP: begin
          if (measure_response__valid) begin
            measure_response__ack  <= 1'b1;
            measure_request__valid <= 1'b0;
            resp_init_q            <= measure_response__initial_delay;
            resp_delay_q           <= measure_response__delay;
            if (!enable) begin
              state <= S_IDLE;
            end else if (measure_response__abort) begin
              status__retries <= status__retries + 3'd1;
              if (status__retries == RETRY_LAST) begin
                status__failed <= 1'b1;
                status__locked <= 1'b0;
                state          <= S_FAIL;
              end else begin
                state <= S_REQUEST;
              end
            end else begin
              state <= S_ACCUM;
            end
          end
        end
        S_ACCUM: begin
          if (!enable) begin
            state <= S_IDLE;
          end else begin
            sample_cnt      <= sample_cnt + LOG2_SAMPLES'(1);
            status__retries <= '0;
            state           <= (sample_cnt == '1) ? S_COMPUTE : S_REQUEST;
          end
        end
        S_COMPUTE: begin
          if (!enable) begin
            state <= S_IDLE;
          end else begin
            dd_q.value <= average;
`ifdef PHASE_MEASURE_TRACK_EN
            if (status__locked && (average == status__phase)) state <= S_LOCKED;
            else                                                state <= S_LOAD;
`else
            state <= S_LOAD;
`endif
          end
        end
        // The load handshake always completes, regardless of enable.
        S_LOAD: begin
          if (dd_q.load && data_delay__load_ack) begin
            dd_q.load      <= 1'b0;
            status__phase  <= dd_q.value;
            status__locked <= 1'b1;
            state          <= enable ? S_LOCKED : S_IDLE;
          end else begin
            dd_q.load <= 1'b1;
          end
        end
        S_LOCKED: begin
          if (!enable) begin
            state <= S_IDLE;
          end
`ifdef PHASE_MEASURE_TRACK_EN
          else if (interval_cnt == INTERVAL_LAST) begin
            state <= S_HOLDOFF;
          end else begin
            interval_cnt <= interval_cnt + IW'(1);
          end
`endif
        end
        S_FAIL: begin
          if (!enable) state <= S_IDLE;
        end
`ifdef PHASE_MEASURE_TRACK_EN
        S_HOLDOFF: begin
          if (!enable) begin
            state <= S_IDLE;
          end else begin
            sample_cnt      <= '0;
            status__retries <= '0;
            state           <= S_REQUEST;
          end
        end
`endif
        default: state <= S_IDLE;
      endcase
    end
  end

  // A response strobe is only legal while a request is outstanding.
  a_resp_only_when_waiting : assert property (
    @(posedge clk) disable iff (!reset_n)
    measure_response__valid |-> (state == S_WAIT_RESP)
  );

endmodule

// File: tb/tb_phase_measure_scheduler.sv
// Scoreboard bench for phase_measure_scheduler: stimulus pushes expected acks
// and load values into a queue, a negedge monitor pops them as the DUT
// presents ack pulses and load requests. Status outputs are checked directly.
module tb_phase_measure_scheduler;

  logic       clk;
  logic       reset_n;
  logic       enable;
  logic       measure_request__valid;
  logic       measure_response__valid;
  logic       measure_response__abort;
  logic       measure_response__initial_value;
  logic [8:0] measure_response__initial_delay;
  logic [8:0] measure_response__delay;
  logic       measure_response__ack;
  logic       data_delay__load;
  logic [8:0] data_delay__value;
  logic       data_delay__load_ack;
  logic       status__locked;
  logic       status__failed;
  logic [8:0] status__phase;
  logic [2:0] status__retries;

  phase_measure_scheduler dut (
    .clk                             (clk),
    .reset_n                         (reset_n),
    .enable                          (enable),
    .measure_request__valid          (measure_request__valid),
    .measure_response__valid         (measure_response__valid),
    .measure_response__abort         (measure_response__abort),
    .measure_response__initial_value (measure_response__initial_value),
    .measure_response__initial_delay (measure_response__initial_delay),
    .measure_response__delay         (measure_response__delay),
    .measure_response__ack           (measure_response__ack),
    .data_delay__load                (data_delay__load),
    .data_delay__value               (data_delay__value),
    .data_delay__load_ack            (data_delay__load_ack),
    .status__locked                  (status__locked),
    .status__failed                  (status__failed),
    .status__phase                   (status__phase),
    .status__retries                 (status__retries)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef enum int {EV_ACK = 1, EV_LOAD = 2} ev_kind_e;
  typedef struct {
    ev_kind_e   kind;
    logic [8:0] value;
  } ev_t;
  ev_t exp_q[$];

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Monitor: pops the scoreboard on every ack pulse and every rising load request.
  ev_t  ev;
  logic prev_load;
  always @(negedge clk) begin
    if (!reset_n) begin
      prev_load = 1'b0;
    end else begin
      if (measure_response__ack) begin
        if (exp_q.size() == 0) begin
          check("ack_unexpected", 32'(measure_response__ack), 32'd0);
        end else begin
          ev = exp_q.pop_front();
          check("ack_event_kind", 32'(EV_ACK), 32'(ev.kind));
        end
      end
      if (data_delay__load && !prev_load) begin
        if (exp_q.size() == 0) begin
          check("load_unexpected", 32'(data_delay__load), 32'd0);
        end else begin
          ev = exp_q.pop_front();
          check("load_event_kind", 32'(EV_LOAD), 32'(ev.kind));
          check("load_value", 32'(data_delay__value), 32'(ev.value));
        end
      end
      prev_load = data_delay__load;
    end
  end

  task automatic wait_request(input int budget, output int waited);
    waited = 0;
    while (!measure_request__valid && waited < budget) begin
      @(negedge clk);
      waited++;
    end
    if (!measure_request__valid) check("request_seen", 32'(measure_request__valid), 32'd1);
  endtask

  // Answers the outstanding request with a one-cycle response strobe.
  task automatic respond(input logic abort, input logic [8:0] init_d, input logic [8:0] dly,
                         output int waited);
    wait_request(64, waited);
    if (!measure_request__valid) return;
    exp_q.push_back('{EV_ACK, 9'd0});
    measure_response__valid         = 1'b1;
    measure_response__abort         = abort;
    measure_response__initial_value = 1'b1;
    measure_response__initial_delay = init_d;
    measure_response__delay         = dly;
    @(negedge clk);
    measure_response__valid         = 1'b0;
    measure_response__abort         = 1'b0;
    measure_response__initial_value = 1'b0;
  endtask

  // Waits for load, raises load_ack after ack_delay load cycles, reports how long load stayed high.
  task automatic serve_load(input int ack_delay, output int held, output int waited);
    waited = 0;
    held   = 0;
    while (!data_delay__load && waited < 64) begin
      @(negedge clk);
      waited++;
    end
    if (!data_delay__load) begin
      check("load_seen", 32'(data_delay__load), 32'd1);
      return;
    end
    for (int j = 0; j < ack_delay; j++) begin
      if (data_delay__load) held++;
      @(negedge clk);
    end
    if (data_delay__load) held++;
    data_delay__load_ack = 1'b1;
    @(negedge clk);
    data_delay__load_ack = 1'b0;
  endtask

  task automatic restart();
    enable = 1'b0;
    repeat (2) @(negedge clk);
    enable = 1'b1;
  endtask

  // Directed vectors: centres per test listed as {initial_delay, delay}.
  logic [8:0] t2_init [4] = '{9'd10, 9'd5, 9'd12, 9'd0};
  logic [8:0] t2_dly  [4] = '{9'd0, 9'd12, 9'd1, 9'd28};

  initial begin
    int w;
    int held;
    reset_n                         = 1'b0;
    enable                          = 1'b0;
    measure_response__valid         = 1'b0;
    measure_response__abort         = 1'b0;
    measure_response__initial_value = 1'b0;
    measure_response__initial_delay = '0;
    measure_response__delay         = '0;
    data_delay__load_ack            = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_request", 32'(measure_request__valid), 32'd0);
    check("rst_ack", 32'(measure_response__ack), 32'd0);
    check("rst_load", 32'(data_delay__load), 32'd0);
    check("rst_value", 32'(data_delay__value), 32'd0);
    check("rst_locked", 32'(status__locked), 32'd0);
    check("rst_failed", 32'(status__failed), 32'd0);
    check("rst_phase", 32'(status__phase), 32'd0);
    check("rst_retries", 32'(status__retries), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // T1: four clean responses centre 20+20=40
    enable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      respond(1'b0, 9'd20, 9'd40, w);
      check("t1_request_latency", 32'(w), 32'd2);
    end
    exp_q.push_back('{EV_LOAD, 9'd40});
    serve_load(0, held, w);
    check("t1_load_latency", 32'(w), 32'd3);
    check("t1_load_held", 32'(held), 32'd1);
    check("t1_load_dropped", 32'(data_delay__load), 32'd0);
    check("t1_locked", 32'(status__locked), 32'd1);
    check("t1_phase", 32'(status__phase), 32'd40);
    check("t1_failed", 32'(status__failed), 32'd0);
`ifdef PHASE_MEASURE_TRACK_EN
    wait_request(1100, w);
    check("track_rerequest", 32'(measure_request__valid), 32'd1);
    for (int i = 0; i < 4; i++) begin
      respond(1'b0, 9'd20, 9'd40, w);
      check("track_locked_held", 32'(status__locked), 32'd1);
    end
    repeat (20) @(negedge clk);
    check("track_no_reload", 32'(data_delay__load), 32'd0);
    check("track_phase", 32'(status__phase), 32'd40);
`else
    repeat (1100) @(negedge clk);
    check("oneshot_no_request", 32'(measure_request__valid), 32'd0);
    check("oneshot_locked", 32'(status__locked), 32'd1);
`endif

    // T2: centres 10,11,12,14 -> 47/4 = 11
    enable = 1'b0;
    @(negedge clk);
    check("t2_locked_kept_in_idle", 32'(status__locked), 32'd1);
    @(negedge clk);
    enable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      respond(1'b0, t2_init[i], t2_dly[i], w);
      if (i == 0) check("t2_locked_cleared", 32'(status__locked), 32'd0);
    end
    exp_q.push_back('{EV_LOAD, 9'd11});
    serve_load(0, held, w);
    check("t2_phase", 32'(status__phase), 32'd11);

    // T3: 500 + 50 saturates to 511
    restart();
    for (int i = 0; i < 4; i++) respond(1'b0, 9'd500, 9'd100, w);
    exp_q.push_back('{EV_LOAD, 9'd511});
    serve_load(0, held, w);
    check("t3_phase", 32'(status__phase), 32'd511);

    // T4: seven consecutive aborts -> FAIL, no load
    restart();
    for (int i = 1; i <= 7; i++) begin
      respond(1'b1, 9'd0, 9'd0, w);
      check($sformatf("t4_retries_%0d", i), 32'(status__retries), 32'(i));
    end
    check("t4_failed", 32'(status__failed), 32'd1);
    check("t4_locked", 32'(status__locked), 32'd0);
    repeat (10) @(negedge clk);
    check("t4_no_request", 32'(measure_request__valid), 32'd0);
    check("t4_no_load", 32'(data_delay__load), 32'd0);
    check("t4_phase_kept", 32'(status__phase), 32'd511);

    // T5: two aborts then four good (100+32=132), load_ack on 5th load cycle
    restart();
    @(negedge clk);
    check("t5_failed_cleared", 32'(status__failed), 32'd0);
    respond(1'b1, 9'd0, 9'd0, w);
    respond(1'b1, 9'd0, 9'd0, w);
    check("t5_retries_2", 32'(status__retries), 32'd2);
    for (int i = 0; i < 4; i++) respond(1'b0, 9'd100, 9'd64, w);
    check("t5_retries_cleared", 32'(status__retries), 32'd0);
    exp_q.push_back('{EV_LOAD, 9'd132});
    serve_load(4, held, w);
    check("t5_load_latency", 32'(w), 32'd3);
    check("t5_load_held", 32'(held), 32'd5);
    check("t5_load_dropped", 32'(data_delay__load), 32'd0);
    check("t5_phase", 32'(status__phase), 32'd132);
    check("t5_locked", 32'(status__locked), 32'd1);

    // T6: enable drops while a request is outstanding
    restart();
    wait_request(64, w);
    enable = 1'b0;
    repeat (3) @(negedge clk);
    check("t6_request_held", 32'(measure_request__valid), 32'd1);
    respond(1'b0, 9'd30, 9'd10, w);
    check("t6_request_dropped", 32'(measure_request__valid), 32'd0);
    repeat (5) @(negedge clk);
    check("t6_idle_no_request", 32'(measure_request__valid), 32'd0);
    check("t6_no_load", 32'(data_delay__load), 32'd0);
    check("t6_locked", 32'(status__locked), 32'd0);
    check("t6_phase", 32'(status__phase), 32'd132);

    // T7: asynchronous reset mid-request
    enable = 1'b1;
    wait_request(64, w);
    reset_n = 1'b0;
    #1;
    check("t7_rst_request", 32'(measure_request__valid), 32'd0);
    check("t7_rst_phase", 32'(status__phase), 32'd0);
    check("t7_rst_retries", 32'(status__retries), 32'd0);
    enable = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
